// File: rtl/ocm_bus_initiator_pkg.sv
// ocm_bus_pkg: shared types and constants for the OCM slot bus initiator.
//   ocm_cmd_t     - one queued command {wrt, adr, wdata}, 25 bits packed
//   ocm_state_e   - bus-cycle sequencer states
//   OCM_IDLE_DATA - value returned on rsp_rdata when no read data exists
package ocm_bus_pkg;

  localparam int OCM_ADR_W  = 16;
  localparam int OCM_DATA_W = 8;

  localparam logic [OCM_DATA_W-1:0] OCM_IDLE_DATA = 8'hFF;

  typedef struct packed {
    logic                  wrt;
    logic [OCM_ADR_W-1:0]  adr;
    logic [OCM_DATA_W-1:0] wdata;
  } ocm_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } ocm_state_e;

endpackage

// File: rtl/ocm_bus_initiator_if.sv
// ocm_bus_if: OCM-style slot bus (req/ack/wrt/adr/dbo/dbi).
//   master - initiator side: drives req, wrt, adr, dbo; receives ack, dbi
//   slave  - target side:    receives req, wrt, adr, dbo; drives ack, dbi
interface ocm_bus_if;
  import ocm_bus_pkg::*;

  logic                  req;
  logic                  ack;
  logic                  wrt;
  logic [OCM_ADR_W-1:0]  adr;
  logic [OCM_DATA_W-1:0] dbo;
  logic [OCM_DATA_W-1:0] dbi;

  modport master (
    output req, wrt, adr, dbo,
    input  ack, dbi
  );

  modport slave (
    input  req, wrt, adr, dbo,
    output ack, dbi
  );
endinterface

// File: rtl/ocm_bus_initiator_fifo.sv
// ocm_cmd_fifo: circular command buffer holding ocm_cmd_t entries.
//   clk_i, rst_n_i - clock, asynchronous active-low reset (pointers only)
//   push_i, din_i  - write one entry; ignored while full
//   pop_i          - drop the head entry; ignored while empty
//   head_o         - entry at the read pointer (valid while !empty_o)
//   empty_o/full_o - occupancy flags, level_o - number of stored entries
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ocm_cmd_fifo
  import ocm_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  ocm_cmd_t                 din_i,
  input  logic                     pop_i,
  output ocm_cmd_t                 head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  ocm_cmd_t         mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: a reset clears the pointers, which discards it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/ocm_bus_initiator.sv
// ocm_bus_initiator: queues register commands and runs one OCM bus cycle
// per command, returning one response per command.
//   clk21m, nreset     - system clock, asynchronous active-low reset
//   cmd_valid/ready    - command handshake; cmd_wrt, cmd_adr, cmd_wdata
//   rsp_valid          - one-cycle pulse with rsp_wrt, rsp_rdata, rsp_timeout
//   busy               - commands queued or a bus cycle in flight
//   bus                - ocm_bus_if master: req/wrt/adr/dbo out, ack/dbi in
// All outputs are registered.
module ocm_bus_initiator
  import ocm_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk21m,
  input  logic                  nreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wrt,
  input  logic [OCM_ADR_W-1:0]  cmd_adr,
  input  logic [OCM_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_wrt,
  output logic [OCM_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  busy,
  ocm_bus_if.master             bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  ocm_state_e            state_q, state_d;
  logic                  req_q, req_d;
  logic                  wrt_q, wrt_d;
  logic [OCM_ADR_W-1:0]  adr_q, adr_d;
  logic [OCM_DATA_W-1:0] dbo_q, dbo_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  cnt_zero_q, cnt_zero_d;
  logic                  tmo_q, tmo_d;
  logic [OCM_DATA_W-1:0] rdata_q, rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_wrt_q, rsp_wrt_d;
  logic [OCM_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_tmo_q, rsp_tmo_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;

  logic                  push, pop;
  ocm_cmd_t              cmd_in, fifo_head;
  logic                  fifo_empty, fifo_full;
  logic [LVL_W-1:0]      fifo_level, level_d;

  // ready_q mirrors !full, so a push is only ever offered when there is room.
  assign push   = cmd_valid && ready_q;
  assign cmd_in = '{wrt: cmd_wrt, adr: cmd_adr, wdata: cmd_wdata};

  ocm_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk21m),
    .rst_n_i (nreset),
    .push_i  (push),
    .din_i   (cmd_in),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    wrt_d       = wrt_q;
    adr_d       = adr_q;
    dbo_d       = dbo_q;
    cnt_d       = cnt_q;
    cnt_zero_d  = cnt_zero_q;
    tmo_d       = tmo_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_wrt_d   = rsp_wrt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_tmo_d   = rsp_tmo_q;
    pop         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          wrt_d   = fifo_head.wrt;
          adr_d   = fifo_head.adr;
          dbo_d   = fifo_head.wdata;
          tmo_d   = 1'b0;
          rdata_d = OCM_IDLE_DATA;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        req_d      = 1'b1;
        cnt_d      = 16'(TIMEOUT);
        cnt_zero_d = 1'b0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.ack) begin
          if (!wrt_q) rdata_d = bus.dbi;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_zero_q) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          // The zero compare is registered to keep it off the ack path; that
          // extra stage is why req stays high for TIMEOUT+2 cycles.
          cnt_zero_d = (cnt_q == 16'd0);
          if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_wrt_d   = wrt_q;
        rsp_rdata_d = rdata_q;
        rsp_tmo_d   = tmo_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Occupancy after this edge drives both the registered ready and busy.
    level_d = fifo_level + LVL_W'(push) - LVL_W'(pop);
    ready_d = (level_d != LVL_W'(FIFO_DEPTH));
    busy_d  = (state_d != ST_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk21m or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      wrt_q       <= 1'b0;
      adr_q       <= '0;
      dbo_q       <= '0;
      cnt_q       <= '0;
      cnt_zero_q  <= 1'b0;
      tmo_q       <= 1'b0;
      rdata_q     <= OCM_IDLE_DATA;
      rsp_valid_q <= 1'b0;
      rsp_wrt_q   <= 1'b0;
      rsp_rdata_q <= OCM_IDLE_DATA;
      rsp_tmo_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wrt_q       <= wrt_d;
      adr_q       <= adr_d;
      dbo_q       <= dbo_d;
      cnt_q       <= cnt_d;
      cnt_zero_q  <= cnt_zero_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wrt_q   <= rsp_wrt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_tmo_q   <= rsp_tmo_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.req     = req_q;
  assign bus.wrt     = wrt_q;
  assign bus.adr     = adr_q;
  assign bus.dbo     = dbo_q;
  assign cmd_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_wrt     = rsp_wrt_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_tmo_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ocm_bus_initiator.sv
// Testbench for ocm_bus_initiator: drives commands, models the slot target
// with per-cycle ack latency, and checks bus cycles and responses against a
// queue-based reference of what each command must produce.
module tb_ocm_bus_initiator;
  import ocm_bus_pkg::*;

  localparam int TMO = 10;

  typedef struct {
    logic       wrt;
    logic [7:0] rdata;
    logic       tmo;
  } rsp_s;

  logic        clk21m = 1'b0;
  logic        nreset;
  logic        cmd_valid, cmd_ready, cmd_wrt;
  logic [15:0] cmd_adr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_wrt, rsp_timeout, busy;
  logic [7:0]  rsp_rdata;

  ocm_bus_if bus ();

  ocm_bus_initiator #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (TMO)
  ) dut (
    .clk21m      (clk21m),
    .nreset      (nreset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wrt     (cmd_wrt),
    .cmd_adr     (cmd_adr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_wrt     (rsp_wrt),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .bus         (bus)
  );

  always #5 clk21m = ~clk21m;

  int cyc = 0;
  always @(posedge clk21m) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Target read data is a fixed function of the address (AEF1 -> 80).
  function automatic logic [7:0] tgt_data(input logic [15:0] a);
    return a[7:0] ^ 8'h71;
  endfunction

  // Reference state shared by driver, target/monitor and main sequence.
  ocm_cmd_t exp_bus[$];
  rsp_s     exp_rsp[$];
  int       lat_plan[$];
  int       rise_q[$];
  int       lat_mode = 1;      // >=0 fixed (0 = never ack), -1 random incl. never, -2 random 1..3
  bit       stray_en = 0;
  int       accepted = 0, rsps = 0, rises = 0;
  int       accept_cyc = 0, last_rise_cyc = 0;
  bit       stalled = 0;
  logic       last_rsp_wrt, last_rsp_tmo;
  logic [7:0] last_rsp_rdata;

  // Target model and monitor, sampling at the falling edge.
  initial begin
    bit        in_req = 0, stable = 1, prev_rsp = 0;
    int        req_len = 0, exp_len = 0, cur_lat = 0, since_fall = 100;
    logic [24:0] snap;
    ocm_cmd_t  e;
    rsp_s      r;
    bus.ack = 1'b0;
    bus.dbi = 8'h00;
    forever begin
      @(negedge clk21m);
      if (!nreset) begin
        in_req = 0; req_len = 0; prev_rsp = 0; since_fall = 100;
        bus.ack = 1'b0;
        continue;
      end
      if (bus.req) begin
        if (!in_req) begin
          in_req = 1; req_len = 0; stable = 1; rises++;
          last_rise_cyc = cyc;
          rise_q.push_back(cyc);
          snap = {bus.wrt, bus.adr, bus.dbo};
          if (lat_plan.size() != 0) cur_lat = lat_plan.pop_front();
          else if (lat_mode == -1) cur_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
          else if (lat_mode == -2) cur_lat = int'($urandom_range(1, 3));
          else cur_lat = lat_mode;
          exp_len = (cur_lat == 0) ? TMO + 2 : cur_lat;
          if (exp_bus.size() == 0) begin
            check_val("bus_unexpected", 1, 0);
          end else begin
            e = exp_bus.pop_front();
            check_val("bus_adr", bus.adr, e.adr);
            check_val("bus_wrt", bus.wrt, e.wrt);
            if (e.wrt) check_val("bus_dbo", bus.dbo, e.wdata);
            if (cur_lat == 0) r = '{e.wrt, 8'hFF, 1'b1};
            else r = '{e.wrt, (e.wrt ? 8'hFF : tgt_data(e.adr)), 1'b0};
            exp_rsp.push_back(r);
          end
        end
        req_len++;
        if ({bus.wrt, bus.adr, bus.dbo} != snap) stable = 0;
        if (cur_lat != 0 && req_len == cur_lat) begin
          bus.ack = 1'b1;
          bus.dbi = tgt_data(bus.adr);
        end else begin
          bus.ack = 1'b0;
          bus.dbi = 8'($urandom);
        end
      end else begin
        bus.ack = stray_en && ($urandom_range(0, 3) == 0);
        bus.dbi = 8'($urandom);
        if (in_req) begin
          in_req = 0;
          check_val("req_len", req_len, exp_len);
          check_val("bus_stable", stable, 1);
          since_fall = 0;
        end
      end
      if (rsp_valid) begin
        rsps++;
        check_val("rsp_pulse", prev_rsp, 0);
        check_val("rsp_after_req", since_fall, 1);
        if (exp_rsp.size() == 0) begin
          check_val("rsp_unexpected", 1, 0);
        end else begin
          r = exp_rsp.pop_front();
          check_val("rsp_wrt", rsp_wrt, r.wrt);
          check_val("rsp_rdata", rsp_rdata, r.rdata);
          check_val("rsp_timeout", rsp_timeout, r.tmo);
        end
        last_rsp_wrt = rsp_wrt; last_rsp_rdata = rsp_rdata; last_rsp_tmo = rsp_timeout;
        check_val("busy_at_rsp", busy, (accepted != rsps));
      end
      prev_rsp = rsp_valid;
      since_fall++;
    end
  end

  task automatic push_cmd(input logic w, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    ocm_cmd_t c;
    @(negedge clk21m);
    cmd_wrt = w; cmd_adr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 1000) begin
      stalled = 1;
      @(negedge clk21m);
      n++;
    end
    if (!cmd_ready) begin
      check_val("push_stuck", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk21m);
    accept_cyc = cyc;
    accepted++;
    c.wrt = w; c.adr = a; c.wdata = d;
    exp_bus.push_back(c);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_bus.size() != 0 || exp_rsp.size() != 0 || accepted != rsps || busy) && n < 3000) begin
      @(negedge clk21m);
      n++;
    end
    check_val("drain_done", (n < 3000), 1);
    @(negedge clk21m);
    check_val("busy_idle", busy, 0);
  endtask

  initial begin
    int s0, r0, hi;
    nreset = 1'b0; cmd_valid = 1'b0; cmd_wrt = 1'b0; cmd_adr = '0; cmd_wdata = '0;

    // Reset state
    repeat (50) @(negedge clk21m);
    check_val("rst_req", bus.req, 0);
    check_val("rst_wrt", bus.wrt, 0);
    check_val("rst_adr", bus.adr, 0);
    check_val("rst_dbo", bus.dbo, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_wrt", rsp_wrt, 0);
    check_val("rst_rsp_rdata", rsp_rdata, 8'hFF);
    check_val("rst_rsp_timeout", rsp_timeout, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_cmd_ready", cmd_ready, 1);
    nreset = 1'b1;
    hi = 0;
    repeat (50) begin
      @(negedge clk21m);
      if (bus.req) hi++;
    end
    check_val("idle_req", hi, 0);
    check_val("idle_ready", cmd_ready, 1);

    // Single write, ack on the 3rd req cycle
    lat_mode = 3;
    s0 = rsps;
    push_cmd(1'b1, 16'hAE02, 8'h0F);
    drain();
    check_val("wr_issue_lat", last_rise_cyc - accept_cyc, 3);
    check_val("wr_rsp_count", rsps - s0, 1);
    check_val("wr_rsp_wrt", last_rsp_wrt, 1);
    check_val("wr_rsp_rdata", last_rsp_rdata, 8'hFF);

    // Read
    lat_mode = 2;
    push_cmd(1'b0, 16'hAEF1, 8'h5A);
    drain();
    check_val("rd_rsp_rdata", last_rsp_rdata, 8'h80);
    check_val("rd_rsp_timeout", last_rsp_tmo, 0);
    check_val("rd_rsp_wrt", last_rsp_wrt, 0);

    // Zero-wait throughput
    lat_mode = 1;
    rise_q.delete();
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 16'h1000 + 16'(i), 8'(i * 3));
    drain();
    check_val("tput_cycles", rise_q.size(), 4);
    for (int i = 0; i + 1 < rise_q.size(); i++)
      check_val("tput_interval", rise_q[i+1] - rise_q[i], 4);

    // Burst with back-pressure
    lat_mode = -2;
    stalled = 0;
    s0 = rsps;
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 4; j++)
        push_cmd(1'b1, 16'hAE00 + 16'(i * 16 + j), 8'($urandom));
    drain();
    check_val("burst_ready_fell", stalled, 1);
    check_val("burst_rsp_count", rsps - s0, 48);

    // Timeout followed by a normal command
    lat_plan.push_back(0);
    lat_plan.push_back(2);
    push_cmd(1'b1, 16'hBEEF, 8'h11);
    push_cmd(1'b0, 16'hAE33, 8'h00);
    drain();
    check_val("tmo_next_rdata", last_rsp_rdata, tgt_data(16'hAE33));
    check_val("tmo_next_flag", last_rsp_tmo, 0);

    // Randomized mix with stray acks outside bus cycles
    lat_mode = -1;
    stray_en = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk21m);
      push_cmd(1'($urandom), 16'($urandom), 8'($urandom));
    end
    drain();
    stray_en = 0;

    // Reset during WAIT with two commands queued
    lat_mode = 0;
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 16'hC000 + 16'(i), 8'hA0);
    begin
      int n = 0;
      while (!bus.req && n < 50) begin @(negedge clk21m); n++; end
      check_val("mid_req_seen", bus.req, 1);
    end
    repeat (3) @(posedge clk21m);
    #3 nreset = 1'b0;
    #1;
    check_val("mid_req_async", bus.req, 0);
    check_val("mid_rsp_valid", rsp_valid, 0);
    check_val("mid_busy", busy, 0);
    check_val("mid_ready", cmd_ready, 1);
    exp_bus.delete(); exp_rsp.delete(); lat_plan.delete();
    repeat (5) @(negedge clk21m);
    accepted = 0; rsps = 0;
    nreset = 1'b1;
    r0 = rises; s0 = rsps;
    repeat (100) @(negedge clk21m);
    check_val("post_rst_bus", rises - r0, 0);
    check_val("post_rst_rsp", rsps - s0, 0);
    check_val("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "global timeout");
  end

endmodule
